// File: rtl/fnd_sched_pkg.sv
// Shared state encoding and display constants for the FND source scheduler.
// The digit-mux stage replaces a blanked digit with BLANK_CODE.
package fnd_sched_pkg;

  typedef enum logic [1:0] {
    ST_CLOCK     = 2'd0,
    ST_STOPWATCH = 2'd1,
    ST_SET       = 2'd2,
    ST_ALARM     = 2'd3
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'hb;
  localparam logic [6:0] MSEC_MAX   = 7'd99;

  function automatic logic [3:0] digit_onehot(input logic [1:0] digit);
    return 4'b0001 << digit;
  endfunction

endpackage

// File: rtl/fnd_blink_timer.sv
// Blink phase generator: toggles o_phase every PERIOD ticks, o_phase=1 means digit OFF.
// Clear has priority over tick and restarts the count in the ON phase.
module fnd_blink_timer #(
  parameter int PERIOD = 500
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_phase
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (i_tick) begin
      if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/fnd_display_scheduler.sv
// Picks the source for the shared 4-digit FND datapath (clock, stopwatch, set, alarm) and
// produces a per-digit blink mask; every output is registered one cycle behind the state.
module fnd_display_scheduler
  import fnd_sched_pkg::*;
#(
  parameter int BLINK_MS         = 500,
  parameter int ALARM_TIMEOUT_MS = 10000,
  parameter int MAX_DATA         = 9999
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_tick_1ms,
  input  logic        i_btn_mode,
  input  logic        i_set_active,
  input  logic [1:0]  i_set_digit,
  input  logic        i_alarm_req,
  input  logic        i_alarm_ack,
  input  logic [13:0] i_clock_data,
  input  logic [6:0]  i_clock_msec,
  input  logic [13:0] i_sw_data,
  input  logic [6:0]  i_sw_msec,
  output logic [13:0] o_count_data,
  output logic [6:0]  o_msec,
  output logic [3:0]  o_blank_mask,
  output logic [1:0]  o_mode,
  output logic        o_alarm_active
);

  localparam int AW = (ALARM_TIMEOUT_MS > 1) ? $clog2(ALARM_TIMEOUT_MS) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TIMEOUT_MS - 1);
  localparam logic [13:0]   DATA_MAX   = 14'(MAX_DATA);

  state_t        r_state;
  state_t        r_saved;
  state_t        w_next;
  state_t        w_exit_to;
  logic [AW-1:0] r_alarm_cnt;
  logic [1:0]    r_set_digit_q;
  logic          w_timeout;
  logic          w_blink_clear;
  logic          w_blink_off;
  logic [13:0]   w_sel_data;
  logic [6:0]    w_sel_msec;
  logic [3:0]    w_blank;

  logic [13:0]   r_count_data;
  logic [6:0]    r_msec;
  logic [3:0]    r_blank_mask;
  logic [1:0]    r_mode;
  logic          r_alarm_active;

  assign w_timeout = (r_state == ST_ALARM) && i_tick_1ms && (r_alarm_cnt == ALARM_LAST);
  // A SET interrupted by the alarm is abandoned if the user released set mode meanwhile.
  assign w_exit_to = ((r_saved == ST_SET) && !i_set_active) ? ST_CLOCK : r_saved;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_CLOCK;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CLOCK: begin
        if (i_alarm_req)       w_next = ST_ALARM;
        else if (i_set_active) w_next = ST_SET;
        else if (i_btn_mode)   w_next = ST_STOPWATCH;
      end
      ST_STOPWATCH: begin
        if (i_alarm_req)     w_next = ST_ALARM;
        else if (i_btn_mode) w_next = ST_CLOCK;
      end
      ST_SET: begin
        if (i_alarm_req)        w_next = ST_ALARM;
        else if (!i_set_active) w_next = ST_CLOCK;
      end
      ST_ALARM: begin
        if (i_alarm_ack || w_timeout) w_next = w_exit_to;
      end
      default: w_next = ST_CLOCK;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_saved     <= ST_CLOCK;
      r_alarm_cnt <= '0;
    end else if ((r_state != ST_ALARM) && (w_next == ST_ALARM)) begin
      r_saved     <= r_state;
      r_alarm_cnt <= '0;
    end else if ((r_state == ST_ALARM) && i_tick_1ms && (r_alarm_cnt != ALARM_LAST)) begin
      r_alarm_cnt <= r_alarm_cnt + AW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    r_set_digit_q <= i_set_digit;
  end

  assign w_blink_clear = (w_next != r_state) || (i_set_digit != r_set_digit_q);

  fnd_blink_timer #(
    .PERIOD(BLINK_MS)
  ) u_blink (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clear(w_blink_clear),
    .i_tick (i_tick_1ms),
    .o_phase(w_blink_off)
  );

  assign w_sel_data = (r_state == ST_STOPWATCH) ? i_sw_data : i_clock_data;
  assign w_sel_msec = (r_state == ST_STOPWATCH) ? i_sw_msec : i_clock_msec;

  always_comb begin
    w_blank = 4'b0000;
    case (r_state)
      ST_SET:   if (w_blink_off) w_blank = digit_onehot(i_set_digit);
      ST_ALARM: if (w_blink_off) w_blank = 4'b1111;
      default:  w_blank = 4'b0000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count_data   <= '0;
      r_msec         <= '0;
      r_blank_mask   <= 4'b0000;
      r_mode         <= 2'd0;
      r_alarm_active <= 1'b0;
    end else begin
      r_count_data   <= (w_sel_data > DATA_MAX) ? DATA_MAX : w_sel_data;
      r_msec         <= (w_sel_msec > MSEC_MAX) ? MSEC_MAX : w_sel_msec;
      r_blank_mask   <= w_blank;
      r_mode         <= r_state;
      r_alarm_active <= (r_state == ST_ALARM);
    end
  end

  assign o_count_data   = r_count_data;
  assign o_msec         = r_msec;
  assign o_blank_mask   = r_blank_mask;
  assign o_mode         = r_mode;
  assign o_alarm_active = r_alarm_active;

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Bench for fnd_display_scheduler: directed steps plus random traffic against a behavioural model.
module tb_fnd_display_scheduler;

  localparam int BLINK = 4;
  localparam int TO    = 20;
  localparam int MAXD  = 9999;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0, btn = 1'b0, set_active = 1'b0, areq = 1'b0, aack = 1'b0;
  logic [1:0]  set_digit = 2'd0;
  logic [13:0] clock_data = 14'd0, sw_data = 14'd0;
  logic [6:0]  clock_msec = 7'd0, sw_msec = 7'd0;
  logic [13:0] count_data;
  logic [6:0]  msec;
  logic [3:0]  blank_mask;
  logic [1:0]  mode;
  logic        alarm_active;

  int checks = 0;
  int errors = 0;

  // Reference model: display state as plain ints, milliseconds counted directly.
  int   m_state = 0, m_saved = 0, m_bcnt = 0, m_acnt = 0;
  bit   m_off = 1'b0;
  logic [1:0] m_dig_prev = 2'd0;

  fnd_display_scheduler #(
    .BLINK_MS(BLINK),
    .ALARM_TIMEOUT_MS(TO),
    .MAX_DATA(MAXD)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_tick_1ms(tick),
    .i_btn_mode(btn),
    .i_set_active(set_active),
    .i_set_digit(set_digit),
    .i_alarm_req(areq),
    .i_alarm_ack(aack),
    .i_clock_data(clock_data),
    .i_clock_msec(clock_msec),
    .i_sw_data(sw_data),
    .i_sw_msec(sw_msec),
    .o_count_data(count_data),
    .o_msec(msec),
    .o_blank_mask(blank_mask),
    .o_mode(mode),
    .o_alarm_active(alarm_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic cyc(input bit t = 1'b0, input bit b = 1'b0, input bit ar = 1'b0, input bit ak = 1'b0);
    int e_mode, e_data, e_msec, e_blank, e_alarm, nxt;
    bit dchg;
    tick = t; btn = b; areq = ar; aack = ak;
    if (reset) begin
      e_mode = 0; e_data = 0; e_msec = 0; e_blank = 0; e_alarm = 0;
      m_state = 0; m_saved = 0; m_bcnt = 0; m_acnt = 0; m_off = 1'b0;
    end else begin
      e_mode  = m_state;
      e_alarm = (m_state == 3) ? 1 : 0;
      e_data  = clampi((m_state == 1) ? int'(sw_data) : int'(clock_data), MAXD);
      e_msec  = clampi((m_state == 1) ? int'(sw_msec) : int'(clock_msec), 99);
      e_blank = (m_state == 2 && m_off) ? (1 << set_digit) : ((m_state == 3 && m_off) ? 15 : 0);
      nxt = m_state;
      if (m_state != 3 && ar) nxt = 3;
      else if (m_state == 0) begin
        if (set_active) nxt = 2;
        else if (b)     nxt = 1;
      end else if (m_state == 1) begin
        if (b) nxt = 0;
      end else if (m_state == 2) begin
        if (!set_active) nxt = 0;
      end else begin
        if (ak || (t && m_acnt == TO - 1))
          nxt = (m_saved == 2 && !set_active) ? 0 : m_saved;
      end
      dchg = (set_digit != m_dig_prev);
      if (nxt != m_state || dchg) begin
        m_bcnt = 0; m_off = 1'b0;
      end else if (t) begin
        m_bcnt++;
        if (m_bcnt == BLINK) begin m_bcnt = 0; m_off = !m_off; end
      end
      if (nxt == 3 && m_state != 3) begin m_saved = m_state; m_acnt = 0; end
      else if (m_state == 3 && t) m_acnt++;
      m_state = nxt;
    end
    m_dig_prev = set_digit;
    @(posedge clk); #1;
    chk("mode", 32'(mode), e_mode);
    chk("count_data", 32'(count_data), e_data);
    chk("msec", 32'(msec), e_msec);
    chk("blank_mask", 32'(blank_mask), e_blank);
    chk("alarm_active", 32'(alarm_active), e_alarm);
    tick = 1'b0; btn = 1'b0; areq = 1'b0; aack = 1'b0;
  endtask

  initial begin
    clock_data = 14'd1234; clock_msec = 7'd12;
    repeat (3) cyc();
    chk("rst_count", 32'(count_data), 0);
    chk("rst_mode", 32'(mode), 0);
    reset = 1'b0;
    cyc();
    chk("post_rst_count", 32'(count_data), 1234);
    chk("post_rst_blank", 32'(blank_mask), 0);

    sw_data = 14'd42; sw_msec = 7'd57;
    cyc(0, 1); cyc();
    chk("sw_mode", 32'(mode), 1);
    chk("sw_count", 32'(count_data), 42);
    chk("sw_msec", 32'(msec), 57);
    cyc(0, 1); cyc();
    chk("back_clock_count", 32'(count_data), 1234);

    set_active = 1'b1; set_digit = 2'd2;
    cyc(); cyc();
    chk("set_mode", 32'(mode), 2);
    repeat (4) cyc(1);
    cyc();
    chk("set_blank_off", 32'(blank_mask), 4);
    repeat (3) cyc(1);
    set_digit = 2'd0;
    cyc(); cyc();
    chk("digit_restart_on", 32'(blank_mask), 0);
    repeat (3) cyc(1);
    cyc();
    chk("digit_still_on", 32'(blank_mask), 0);
    cyc(1); cyc();
    chk("digit0_off", 32'(blank_mask), 1);
    set_active = 1'b0;
    cyc(); cyc();
    chk("set_exit_mode", 32'(mode), 0);

    cyc(0, 1); cyc();
    cyc(0, 0, 1); cyc();
    chk("alarm_mode", 32'(mode), 3);
    chk("alarm_active", 32'(alarm_active), 1);
    repeat (4) cyc(1);
    cyc();
    chk("alarm_blank_off", 32'(blank_mask), 15);
    cyc(0, 0, 0, 1); cyc();
    chk("ack_to_sw", 32'(mode), 1);

    cyc(0, 0, 1); cyc();
    repeat (19) cyc(1);
    cyc();
    chk("timeout_not_yet", 32'(mode), 3);
    cyc(1); cyc();
    chk("timeout_to_sw", 32'(mode), 1);

    cyc(0, 1);
    cyc(0, 1, 1); cyc();
    chk("req_beats_btn", 32'(mode), 3);
    repeat (10) cyc(1);
    cyc(0, 0, 1);
    repeat (9) cyc(1);
    cyc();
    chk("retrigger_still_alarm", 32'(mode), 3);
    cyc(1); cyc();
    chk("retrigger_no_restart", 32'(mode), 0);

    clock_data = 14'h3FFF; clock_msec = 7'd120;
    cyc(); cyc();
    chk("clamp_data", 32'(count_data), 9999);
    chk("clamp_msec", 32'(msec), 99);

    cyc(0, 0, 1); repeat (6) cyc(1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_alarm_mode", 32'(mode), 0);
    chk("rst_alarm_active", 32'(alarm_active), 0);
    chk("rst_alarm_blank", 32'(blank_mask), 0);
    cyc();

    for (int i = 0; i < 3000; i++) begin
      clock_data = 14'($urandom);
      sw_data    = 14'($urandom);
      clock_msec = 7'($urandom);
      sw_msec    = 7'($urandom);
      if ($urandom_range(0, 39) == 0) set_active = ~set_active;
      if ($urandom_range(0, 29) == 0) set_digit = 2'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      cyc($urandom_range(0, 1) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0);
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
